// File: rtl/dm_pkg.sv
// Shared types and helpers for the sized big-endian data memory controller:
// access-size encodings, controller FSM states and byte-lane helpers.
package dm_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_t;

   // The unused encoding 2'b11 behaves as a word access.
   function automatic size_t normSize(input logic [1:0] raw);
      size_t sz;
      case (raw)
         2'b00:   sz = SZ_BYTE;
         2'b01:   sz = SZ_HALF;
         default: sz = SZ_WORD;
      endcase
      return sz;
   endfunction

   // Bit 3 is lane [31:24], so offset 0 is the most significant byte.
   function automatic logic [3:0] byteEnable(input size_t size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b1000 >> off;
         SZ_HALF: be = off[1] ? 4'b0011 : 4'b1100;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic isMisaligned(input size_t size, input logic [1:0] off);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         default: bad = (off != 2'b00);
      endcase
      return bad;
   endfunction

   function automatic logic [1:0] alignOff(input size_t size, input logic [1:0] off);
      logic [1:0] res;
      case (size)
         SZ_BYTE: res = off;
         SZ_HALF: res = {off[1], 1'b0};
         default: res = 2'b00;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dm_sized_ctrl_if.sv
// Request/response bundle between the MEM stage (master) and the sized data
// memory controller (slave).
interface dm_sized_ctrl_if #(
   parameter int ADDR_W = 12
);
   // Valid/ready: a transfer happens on a rising edge where valid and ready are
   // both high; the source holds its payload stable until that edge and the
   // sink never makes ready depend on payload contents.
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dm_lane_align.sv
// Extracts the byte/half/word field of a big-endian 32-bit word and right-aligns
// it with sign or zero extension.
module dm_lane_align
   import dm_pkg::*;
(
   input  logic [31:0] word,
   input  size_t       size,
   input  logic [1:0]  off,
   input  logic        sgn,
   output logic [31:0] data
);

   logic [7:0]  byteField;
   logic [15:0] halfField;

   always_comb begin
      byteField = 8'h00;
      halfField = 16'h0000;
      data      = word;
      case (off)
         2'd0:    byteField = word[31:24];
         2'd1:    byteField = word[23:16];
         2'd2:    byteField = word[15:8];
         default: byteField = word[7:0];
      endcase
      halfField = off[1] ? word[15:0] : word[31:16];
      case (size)
         SZ_BYTE: data = {{24{sgn & byteField[7]}}, byteField};
         SZ_HALF: data = {{16{sgn & halfField[15]}}, halfField};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/dm_sized_ctrl.sv
// Big-endian byte/half/word data memory controller: IDLE -> ACCESS -> RESP.
// Define DM_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning.
module dm_sized_ctrl
   import dm_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   dm_sized_ctrl_if.slave  bus,
   output state_t          dbgState
);

   localparam int DEPTH = 2 ** (ADDR_W - 2);

   if (DATA_W != 32) begin : gBadWidth
      $error("dm_sized_ctrl: DATA_W must be 32");
   end

   state_t            state;
   state_t            nextState;
   logic              reqReady;

   logic              reqWe;
   logic              reqSigned;
   size_t             reqSize;
   logic [ADDR_W-1:0] reqAddr;
   logic [31:0]       reqWdata;

   logic [31:0]       respData;
   logic              respErr;

   logic [31:0]       mem [DEPTH];

   logic [ADDR_W-3:0] wordIdx;
   logic [1:0]        rawOff;
   logic [1:0]        effOff;
   logic              accessOk;
   logic              errFlag;
   logic [3:0]        laneEn;
   logic [31:0]       laneData;
   logic [31:0]       rdWord;
   logic [31:0]       loadData;

   assign wordIdx = reqAddr[ADDR_W-1:2];
   assign rawOff  = reqAddr[1:0];

`ifdef DM_MISALIGN_TRAP_EN
   assign effOff   = rawOff;
   assign errFlag  = isMisaligned(reqSize, rawOff);
   assign accessOk = ~errFlag;
`else
   assign effOff   = alignOff(reqSize, rawOff);
   assign errFlag  = 1'b0;
   assign accessOk = 1'b1;
`endif

   assign laneEn = byteEnable(reqSize, effOff);

   // Store data is replicated across lanes; the byte enables pick the live copy.
   always_comb begin
      laneData = reqWdata;
      case (reqSize)
         SZ_BYTE: laneData = {4{reqWdata[7:0]}};
         SZ_HALF: laneData = {2{reqWdata[15:0]}};
         default: laneData = reqWdata;
      endcase
   end

   assign rdWord = mem[wordIdx];

   dm_lane_align uAlign (
      .word (rdWord),
      .size (reqSize),
      .off  (effOff),
      .sgn  (reqSigned),
      .data (loadData)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      reqReady  = 1'b0;
      case (state)
         ST_IDLE: begin
            reqReady = 1'b1;
            if (bus.req_valid) nextState = ST_ACCESS;
         end
         ST_ACCESS: nextState = ST_RESP;
         ST_RESP:   if (bus.resp_ready) nextState = ST_IDLE;
         default:   nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reqWe     <= 1'b0;
         reqSigned <= 1'b0;
         reqSize   <= SZ_WORD;
         reqAddr   <= '0;
         reqWdata  <= '0;
      end else if (state == ST_IDLE && bus.req_valid) begin
         reqWe     <= bus.req_we;
         reqSigned <= bus.req_signed;
         reqSize   <= normSize(bus.req_size);
         reqAddr   <= bus.req_addr;
         reqWdata  <= bus.req_wdata;
      end
   end

   // Array write: gated by the reset-held state, so a reset during ACCESS drops it.
   always_ff @(posedge clk) begin
      if (state == ST_ACCESS && reqWe && accessOk) begin
         for (int i = 0; i < 4; i++) begin
            if (laneEn[i]) mem[wordIdx][8*i +: 8] <= laneData[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         respData <= '0;
         respErr  <= 1'b0;
      end else if (state == ST_ACCESS) begin
         respData <= (reqWe || !accessOk) ? 32'h0 : loadData;
         respErr  <= errFlag;
      end
   end

   assign bus.req_ready  = reqReady;
   assign bus.resp_valid = (state == ST_RESP);
   assign bus.resp_rdata = respData;
   assign bus.resp_err   = respErr;
   assign dbgState       = state;

endmodule

// File: tb/tb_dm_sized_ctrl.sv
// Directed scoreboard bench for dm_sized_ctrl; expectations follow DM_MISALIGN_TRAP_EN.
module tb_dm_sized_ctrl;
   import dm_pkg::*;

   logic   clk;
   logic   rst_n;
   state_t dbgState;

   int n_cmp = 0;
   int n_bad = 0;
   logic [32:0] exp_q[$];

   dm_sized_ctrl_if #(.ADDR_W(12)) bus ();

   dm_sized_ctrl #(.ADDR_W(12), .DATA_W(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .dbgState (dbgState)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // driver: entered and left at #1 after a rising edge; returns in ACCESS
   task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [11:0] addr, input logic [31:0] wdata,
                        input logic [32:0] exp, input bit track);
      int guard = 0;
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_valid  = 1'b1;
      if (track) exp_q.push_back(exp);
      while (!bus.req_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 100) begin
         n_cmp++; n_bad++;
         $display("FAIL req_timeout: got req_ready=0 want 1");
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 200) begin
         n_cmp++; n_bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && bus.resp_valid && bus.resp_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_resp: got %h want none", {bus.resp_err, bus.resp_rdata});
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            if ({bus.resp_err, bus.resp_rdata} !== e) begin
               n_bad++;
               $display("FAIL resp: got err=%b data=%h want err=%b data=%h",
                        bus.resp_err, bus.resp_rdata, e[32], e[31:0]);
            end
         end
      end
   end

   localparam logic WR = 1'b1;
   localparam logic RD = 1'b0;

   initial begin
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'b00;
      bus.req_signed = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.resp_ready = 1'b1;

      // 1. reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", {31'b0, bus.req_ready}, 32'h1);
      check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
      check("rst_resp_rdata", bus.resp_rdata, 32'h0);
      check("rst_resp_err", {31'b0, bus.resp_err}, 32'h0);
      check("rst_state", {30'b0, dbgState}, {30'b0, ST_IDLE});
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 2. word store then big-endian byte loads
      issue(WR, 2'b10, 1'b0, 12'h010, 32'h8899AABB, 33'h0, 1'b1);
      issue(RD, 2'b00, 1'b1, 12'h010, 32'h0, {1'b0, 32'hFFFFFF88}, 1'b1);
      issue(RD, 2'b00, 1'b1, 12'h011, 32'h0, {1'b0, 32'hFFFFFF99}, 1'b1);
      issue(RD, 2'b00, 1'b1, 12'h012, 32'h0, {1'b0, 32'hFFFFFFAA}, 1'b1);
      issue(RD, 2'b00, 1'b1, 12'h013, 32'h0, {1'b0, 32'hFFFFFFBB}, 1'b1);
      issue(RD, 2'b00, 1'b0, 12'h011, 32'h0, {1'b0, 32'h00000099}, 1'b1);

      // 3. half store merges into the low lane only
      issue(WR, 2'b10, 1'b0, 12'h020, 32'h11223344, 33'h0, 1'b1);
      issue(WR, 2'b01, 1'b0, 12'h022, 32'h0000BEEF, 33'h0, 1'b1);
      issue(RD, 2'b10, 1'b0, 12'h020, 32'h0, {1'b0, 32'h1122BEEF}, 1'b1);
      issue(RD, 2'b01, 1'b1, 12'h022, 32'h0, {1'b0, 32'hFFFFBEEF}, 1'b1);
      issue(RD, 2'b01, 1'b0, 12'h020, 32'h0, {1'b0, 32'h00001122}, 1'b1);
      issue(RD, 2'b00, 1'b1, 12'h022, 32'h0, {1'b0, 32'hFFFFFFBE}, 1'b1);
      issue(RD, 2'b10, 1'b1, 12'h020, 32'h0, {1'b0, 32'h1122BEEF}, 1'b1);

      // 4. byte store into lane 3, latency on the following load, size 2'b11
      issue(WR, 2'b10, 1'b0, 12'h030, 32'h00000000, 33'h0, 1'b1);
      issue(WR, 2'b00, 1'b0, 12'h033, 32'hFFFFFF5A, 33'h0, 1'b1);
      issue(RD, 2'b10, 1'b0, 12'h030, 32'h0, {1'b0, 32'h0000005A}, 1'b1);
      check("lat_after_accept", {31'b0, bus.resp_valid}, 32'h0);
      @(posedge clk); #1;
      check("lat_second_edge", {31'b0, bus.resp_valid}, 32'h1);
      issue(RD, 2'b11, 1'b1, 12'h030, 32'h0, {1'b0, 32'h0000005A}, 1'b1);

      // top of the array
      issue(WR, 2'b10, 1'b0, 12'hFFC, 32'h0BADC0DE, 33'h0, 1'b1);
      issue(RD, 2'b10, 1'b0, 12'hFFC, 32'h0, {1'b0, 32'h0BADC0DE}, 1'b1);
      issue(RD, 2'b01, 1'b1, 12'hFFE, 32'h0, {1'b0, 32'hFFFFC0DE}, 1'b1);
      issue(RD, 2'b00, 1'b0, 12'hFFF, 32'h0, {1'b0, 32'h000000DE}, 1'b1);
      drain();

      // 5. back-pressure
      bus.resp_ready = 1'b0;
      issue(RD, 2'b10, 1'b0, 12'h010, 32'h0, {1'b0, 32'h8899AABB}, 1'b1);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         check("stall_resp_valid", {31'b0, bus.resp_valid}, 32'h1);
         check("stall_resp_rdata", bus.resp_rdata, 32'h8899AABB);
         check("stall_req_ready", {31'b0, bus.req_ready}, 32'h0);
         @(posedge clk); #1;
      end
      bus.resp_ready = 1'b1;
      drain();

      // 6. misaligned word store, then reset during ACCESS
      issue(WR, 2'b10, 1'b0, 12'h040, 32'h01020304, 33'h0, 1'b1);
`ifdef DM_MISALIGN_TRAP_EN
      issue(WR, 2'b10, 1'b0, 12'h041, 32'hCAFEF00D, {1'b1, 32'h0}, 1'b1);
      issue(RD, 2'b10, 1'b0, 12'h040, 32'h0, {1'b0, 32'h01020304}, 1'b1);
      issue(RD, 2'b01, 1'b1, 12'h043, 32'h0, {1'b1, 32'h00000000}, 1'b1);
      issue(RD, 2'b00, 1'b0, 12'h041, 32'h0, {1'b0, 32'h00000002}, 1'b1);
`else
      issue(WR, 2'b10, 1'b0, 12'h041, 32'hCAFEF00D, {1'b0, 32'h0}, 1'b1);
      issue(RD, 2'b10, 1'b0, 12'h040, 32'h0, {1'b0, 32'hCAFEF00D}, 1'b1);
      issue(RD, 2'b01, 1'b1, 12'h043, 32'h0, {1'b0, 32'hFFFFF00D}, 1'b1);
      issue(RD, 2'b00, 1'b0, 12'h041, 32'h0, {1'b0, 32'h000000FE}, 1'b1);
`endif
      issue(WR, 2'b10, 1'b0, 12'h050, 32'h00000000, 33'h0, 1'b1);
      drain();
      issue(WR, 2'b10, 1'b0, 12'h050, 32'hDEADBEEF, 33'h0, 1'b0);
      rst_n = 1'b0;
      #2;
      check("midrst_req_ready", {31'b0, bus.req_ready}, 32'h1);
      check("midrst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("midrst_state", {30'b0, dbgState}, {30'b0, ST_IDLE});
      issue(RD, 2'b10, 1'b0, 12'h050, 32'h0, {1'b0, 32'h00000000}, 1'b1);
      drain();
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
